// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: requester ids, arbiter states and refresh token limit shared by the arbiter files
package sdram_arb_pkg;
  typedef enum logic [2:0] {NONE, VID, DMA, CPU, RFSH} req_id_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RFSH, ST_WAIT} state_t;
  localparam int TOKEN_MAX = 4;
endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: free-running interval counter that accrues refresh tokens, consumed by done
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_CYCLES = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic done,
  output logic urgent,
  output logic pending
);
  localparam int CW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_tokens;
  logic w_wrap, w_inc, w_dec;
  always_comb begin
    w_wrap = r_cnt == CW'(REFRESH_CYCLES - 1);
    // a wrap and a completed refresh in one cycle cancel, even when saturated
    w_inc = w_wrap & ~done & (r_tokens != 3'(TOKEN_MAX));
    w_dec = done & ~w_wrap & (r_tokens != 3'd0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_tokens <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      r_tokens <= r_tokens + {2'b0, w_inc} - {2'b0, w_dec};
    end
  end
  assign urgent = r_tokens >= 3'd2;
  assign pending = r_tokens == 3'd1;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: video/DMA/CPU access and refresh arbitration in front of a single SDRAM controller
module sdram_arbiter #(
  parameter int ADDR_W = 22,
  parameter int REFRESH_CYCLES = 250
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic              dma_req,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              dma_we,
  input  logic              cpu_we,
  input  logic [15:0]       dma_din,
  input  logic [15:0]       cpu_din,
  input  logic [1:0]        dma_ds,
  input  logic [1:0]        cpu_ds,
  output logic              vid_ack,
  output logic              dma_ack,
  output logic              cpu_ack,
  output logic [15:0]       rdata,
  output logic              mem_req,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_ds,
  input  logic              mem_ack,
  input  logic [15:0]       mem_dout
);
  import sdram_arb_pkg::*;
  state_t r_state;
  req_id_t r_grant, w_win;
  logic r_cpu_last, r_vid_ack, r_dma_ack, r_cpu_ack, r_mem_req, r_mem_refresh, r_mem_we;
  logic [15:0] r_rdata, r_mem_din;
  logic [ADDR_W-1:0] r_mem_addr, w_addr;
  logic [1:0] r_mem_ds, w_ds;
  logic [15:0] w_din;
  logic w_vid, w_dma, w_cpu, w_urgent, w_pending, w_done, w_we;
  sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
    .clk(clk), .reset(reset), .done(w_done), .urgent(w_urgent), .pending(w_pending)
  );
  always_comb begin
    // a requester whose ack is showing is still holding its request from the finished access
    w_vid = vid_req & ~r_vid_ack;
    w_dma = dma_req & ~r_dma_ack;
    w_cpu = cpu_req & ~r_cpu_ack;
    w_win = w_vid ? VID : w_urgent ? RFSH : (w_dma & (~w_cpu | r_cpu_last)) ? DMA :
            w_cpu ? CPU : w_pending ? RFSH : NONE;
    w_addr = w_win == VID ? vid_addr : w_win == DMA ? dma_addr : cpu_addr;
    w_we = w_win == DMA ? dma_we : w_win == CPU ? cpu_we : 1'b0;
    w_din = w_win == DMA ? dma_din : w_win == CPU ? cpu_din : 16'h0;
    w_ds = w_win == DMA ? dma_ds : w_win == CPU ? cpu_ds : 2'b11;
    w_done = r_state == ST_WAIT && mem_ack && r_grant == RFSH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= NONE;
      r_cpu_last <= 1'b1;
      r_vid_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_refresh <= 1'b0;
      r_mem_addr <= '0;
      r_mem_we <= 1'b0;
      r_mem_din <= '0;
      r_mem_ds <= '0;
      r_rdata <= '0;
    end else begin
      r_vid_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_refresh <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (w_win == RFSH) begin
            r_state <= ST_RFSH;
            r_mem_refresh <= 1'b1;
            r_grant <= RFSH;
          end else if (w_win != NONE) begin
            r_state <= ST_ISSUE;
            r_mem_req <= 1'b1;
            r_grant <= w_win;
            r_mem_addr <= w_addr;
            r_mem_we <= w_we;
            r_mem_din <= w_din;
            r_mem_ds <= w_ds;
            if (w_win != VID) r_cpu_last <= w_win == CPU;
          end
        ST_ISSUE, ST_RFSH: r_state <= ST_WAIT;
        default:
          if (mem_ack) begin
            r_state <= ST_IDLE;
            r_vid_ack <= r_grant == VID;
            r_dma_ack <= r_grant == DMA;
            r_cpu_ack <= r_grant == CPU;
            if (r_grant != RFSH) r_rdata <= mem_dout;
          end
      endcase
    end
  end
  assign vid_ack = r_vid_ack;
  assign dma_ack = r_dma_ack;
  assign cpu_ack = r_cpu_ack;
  assign rdata = r_rdata;
  assign mem_req = r_mem_req;
  assign mem_refresh = r_mem_refresh;
  assign mem_addr = r_mem_addr;
  assign mem_we = r_mem_we;
  assign mem_din = r_mem_din;
  assign mem_ds = r_mem_ds;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench with a fixed-latency SDRAM controller model per arbiter instance
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;
  localparam int AW = 22;
  typedef struct {req_id_t id; bit rd_chk; logic [15:0] rd;} exp_t;
  typedef struct {logic [AW-1:0] addr; logic we; logic [15:0] din; logic [1:0] ds;} cmd_t;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic vid_req = 0, dma_req = 0, cpu_req = 0;
  logic [AW-1:0] vid_addr = 0, dma_addr = 0, cpu_addr = 0;
  logic dma_we = 0, cpu_we = 0;
  logic [15:0] dma_din = 0, cpu_din = 0;
  logic [1:0] dma_ds = 0, cpu_ds = 0;
  logic vid_ack, dma_ack, cpu_ack, mem_req, mem_refresh, mem_we;
  logic [15:0] rdata, mem_din;
  logic [AW-1:0] mem_addr;
  logic [1:0] mem_ds;
  logic mem_ack = 0;
  logic [15:0] mem_dout = 0;
  logic rr_dma_req = 0, rr_cpu_req = 0;
  logic rr_vid_ack, rr_dma_ack, rr_cpu_ack, rr_mem_req, rr_mem_refresh, rr_mem_we;
  logic [15:0] rr_rdata, rr_mem_din;
  logic [AW-1:0] rr_mem_addr;
  logic [1:0] rr_mem_ds;
  logic rr_mem_ack = 0;
  logic [15:0] rr_mem_dout = 0;
  int errors = 0, checks = 0, cyc = 0, n_acks = 0, n_req = 0, last_req_cyc = 0, last_ack_cyc = 0;
  int lat_r = 3, max_tok = 0, rfsh_held = 0, rr_cpu_acks = 0, rr_dma_acks = 0, rr_cmds = 0;
  bit rr_hold = 0, saw_pend = 0;
  exp_t exp_q[$];
  cmd_t cmd_q[$];
  exp_t e;
  cmd_t c;
  req_id_t aid;

  sdram_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .vid_req(vid_req), .dma_req(dma_req), .cpu_req(cpu_req),
    .vid_addr(vid_addr), .dma_addr(dma_addr), .cpu_addr(cpu_addr), .dma_we(dma_we), .cpu_we(cpu_we),
    .dma_din(dma_din), .cpu_din(cpu_din), .dma_ds(dma_ds), .cpu_ds(cpu_ds),
    .vid_ack(vid_ack), .dma_ack(dma_ack), .cpu_ack(cpu_ack), .rdata(rdata),
    .mem_req(mem_req), .mem_refresh(mem_refresh), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_ds(mem_ds), .mem_ack(mem_ack), .mem_dout(mem_dout)
  );
  sdram_arbiter #(.ADDR_W(AW), .REFRESH_CYCLES(8)) dut_r (
    .clk(clk), .reset(reset), .vid_req(1'b0), .dma_req(rr_dma_req), .cpu_req(rr_cpu_req),
    .vid_addr(vid_addr), .dma_addr(dma_addr), .cpu_addr(cpu_addr), .dma_we(dma_we), .cpu_we(cpu_we),
    .dma_din(dma_din), .cpu_din(cpu_din), .dma_ds(dma_ds), .cpu_ds(cpu_ds),
    .vid_ack(rr_vid_ack), .dma_ack(rr_dma_ack), .cpu_ack(rr_cpu_ack), .rdata(rr_rdata),
    .mem_req(rr_mem_req), .mem_refresh(rr_mem_refresh), .mem_addr(rr_mem_addr), .mem_we(rr_mem_we),
    .mem_din(rr_mem_din), .mem_ds(rr_mem_ds), .mem_ack(rr_mem_ack), .mem_dout(rr_mem_dout)
  );

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [AW-1:0] a, input logic we, input logic [15:0] din, input logic [1:0] ds);
    cmd_t t;
    t.addr = a; t.we = we; t.din = din; t.ds = ds;
    cmd_q.push_back(t);
  endtask

  task automatic push_exp(input req_id_t id, input bit rd_chk, input logic [15:0] rd);
    exp_t t;
    t.id = id; t.rd_chk = rd_chk; t.rd = rd;
    exp_q.push_back(t);
  endtask

  task automatic wait_acks(input int target, input bit drop);
    for (int i = 0; i < 200 && n_acks < target; i++) begin
      step();
      if (drop) begin
        if (vid_ack) vid_req = 0;
        if (dma_ack) dma_req = 0;
        if (cpu_ack) cpu_req = 0;
      end
    end
    chk("ack_count", n_acks, target);
  endtask

  // controller model: mem_ack three cycles after a command, read data derived from the address
  initial begin
    int cnt = 0;
    logic [AW-1:0] a = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_ack = 1;
          mem_dout = a[15:0] ^ 16'hACDB;
        end
      end
      if (mem_req | mem_refresh) begin
        cnt = 3;
        a = mem_addr;
      end
    end
  end

  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      rr_mem_ack = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          rr_mem_ack = 1;
          rr_mem_dout = rr_mem_addr[15:0];
        end
      end
      if (rr_mem_req | rr_mem_refresh) begin
        cnt = lat_r;
        rr_cmds++;
      end
    end
  end

  always @(negedge clk) if (!reset) begin
    if (vid_ack | dma_ack | cpu_ack) begin
      n_acks++;
      last_ack_cyc = cyc;
      chk("ack_onehot", 32'(vid_ack) + 32'(dma_ack) + 32'(cpu_ack), 1);
      aid = vid_ack ? VID : dma_ack ? DMA : CPU;
      if (exp_q.size() == 0) chk("unexpected_ack", {29'b0, vid_ack, dma_ack, cpu_ack}, 0);
      else begin
        e = exp_q.pop_front();
        chk("ack_id", 32'(aid), 32'(e.id));
        if (e.rd_chk) chk("rdata", rdata, e.rd);
      end
    end
    if (mem_req | mem_refresh) chk("req_and_rfsh", mem_req & mem_refresh, 0);
    if (mem_req) begin
      n_req++;
      last_req_cyc = cyc;
      if (cmd_q.size() == 0) chk("unexpected_req", {31'b0, mem_req}, 0);
      else begin
        c = cmd_q.pop_front();
        chk("cmd_addr", mem_addr, c.addr);
        chk("cmd_fields", {mem_we, mem_ds, mem_din}, {c.we, c.ds, c.din});
      end
    end
  end

  always @(negedge clk) if (!reset) begin
    if (32'(dut_r.u_timer.r_tokens) > max_tok) max_tok = 32'(dut_r.u_timer.r_tokens);
    if (rr_cpu_ack) rr_cpu_acks++;
    if (rr_dma_ack) rr_dma_acks++;
    if (rr_mem_refresh) begin
      chk("rr_req_and_rfsh", rr_mem_req, 0);
      if (rr_hold) begin
        rfsh_held++;
        chk("rfsh_urgent_only", dut_r.u_timer.r_tokens >= 3'd2, 1);
      end else if (dut_r.u_timer.r_tokens == 3'd1) saw_pend = 1;
    end
  end

  initial begin
    int t0, r0, base;
    repeat (3) step();
    chk("rst_ctl", {vid_ack, dma_ack, cpu_ack, mem_req, mem_refresh, mem_we, mem_ds}, 0);
    chk("rst_data", {rdata, mem_din}, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 0;
    step();
    // single CPU read: mem_req one cycle after the request, ack four cycles after that
    cpu_addr = 22'h1234; cpu_we = 0; cpu_din = 16'h0; cpu_ds = 2'b11;
    push_cmd(22'h1234, 0, 16'h0, 2'b11);
    push_exp(CPU, 1, 16'hBEEF);
    t0 = cyc; r0 = n_req; base = n_acks;
    cpu_req = 1;
    wait_acks(base + 1, 1);
    chk("single_req_cycle", last_req_cyc, t0 + 1);
    chk("single_req_count", n_req - r0, 1);
    chk("single_ack_cycle", last_ack_cyc, t0 + 5);
    step();
    // three requesters rising together
    vid_addr = 22'h0A0;
    dma_addr = 22'h1B1; dma_we = 1; dma_din = 16'h5A5A; dma_ds = 2'b01;
    cpu_addr = 22'h2C2; cpu_we = 0; cpu_din = 16'h1111; cpu_ds = 2'b10;
    push_cmd(22'h0A0, 0, 16'h0, 2'b11);
    push_cmd(22'h1B1, 1, 16'h5A5A, 2'b01);
    push_cmd(22'h2C2, 0, 16'h1111, 2'b10);
    push_exp(VID, 1, 16'hAC7B);
    push_exp(DMA, 0, 16'h0);
    push_exp(CPU, 1, 16'hAE19);
    base = n_acks;
    vid_req = 1; dma_req = 1; cpu_req = 1;
    wait_acks(base + 3, 1);
    step();
    // DMA and CPU held continuously alternate
    dma_addr = 22'h3D3; dma_we = 1; dma_din = 16'hC0DE; dma_ds = 2'b11;
    cpu_addr = 22'h0E4; cpu_we = 0; cpu_din = 16'h2222; cpu_ds = 2'b01;
    for (int i = 0; i < 3; i++) begin
      push_cmd(22'h3D3, 1, 16'hC0DE, 2'b11);
      push_cmd(22'h0E4, 0, 16'h2222, 2'b01);
      push_exp(DMA, 0, 16'h0);
      push_exp(CPU, 1, 16'hAC3F);
    end
    base = n_acks;
    dma_req = 1; cpu_req = 1;
    wait_acks(base + 6, 0);
    dma_req = 0; cpu_req = 0;
    step();
    // reset while waiting for the controller: the late mem_ack must be ignored
    cpu_addr = 22'h155;
    push_cmd(22'h155, 0, 16'h2222, 2'b01);
    r0 = n_req;
    cpu_req = 1;
    for (int i = 0; i < 20 && n_req == r0; i++) step();
    chk("abort_req_seen", n_req, r0 + 1);
    step();
    chk("abort_in_wait", 32'(dut.r_state), 32'(ST_WAIT));
    reset = 1; cpu_req = 0;
    step();
    chk("abort_rst_ctl", {vid_ack, dma_ack, cpu_ack, mem_req, mem_refresh, mem_we, mem_ds}, 0);
    chk("abort_rst_data", {rdata, mem_din}, 0);
    chk("abort_rst_addr", mem_addr, 0);
    chk("abort_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    reset = 0;
    base = n_acks;
    repeat (6) step();
    chk("abort_no_ack", n_acks - base, 0);
    chk("abort_idle", 32'(dut.r_state), 32'(ST_IDLE));
    // refresh tokens against a continuously busy DMA/CPU pair, REFRESH_CYCLES=8
    reset = 1;
    repeat (2) step();
    reset = 0;
    rr_hold = 1; lat_r = 3;
    rr_dma_req = 1; rr_cpu_req = 1;
    repeat (40) step();
    lat_r = 40;
    base = rr_cmds;
    for (int i = 0; i < 20 && rr_cmds == base; i++) step();
    lat_r = 3;
    repeat (80) step();
    chk("tok_saturate", max_tok, 4);
    chk("rfsh_ahead_of_cpu", rfsh_held > 0, 1);
    chk("rr_both_served", rr_cpu_acks > 0 && rr_dma_acks > 0, 1);
    rr_dma_req = 0; rr_cpu_req = 0; rr_hold = 0;
    repeat (100) step();
    chk("pending_rfsh_idle", saw_pend, 1);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("cmd_q_empty", cmd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
